// File: rtl/freq_ctrl.sv
// freq_ctrl: sequencer around the digit frequency counter in the Huffman
// front end. A Go pulse clears the counter, then a valid/ready symbol
// stream is turned into registered increment commands. After a two-cycle
// settle window the (symbol, frequency) table is serialised downstream over
// a valid/ready handshake.
// Optional build macro FREQ_SKIP_ZERO_EN: emit only entries with a nonzero
// frequency. Without it, all NSYM entries are emitted in ascending order.
module freq_ctrl #(
  parameter int NSYM     = 10,
  parameter int CW       = 8,
  parameter int MAX_SYMS = 255
) (
  input  logic              Clk_in,
  input  logic              nRst,
  input  logic              Go,
  output logic              Busy,
  output logic              Done,
  input  logic              Sym_valid,
  input  logic [3:0]        Sym_data,
  input  logic              Sym_last,
  output logic              Sym_ready,
  output logic              Cnt_clr,
  output logic              Cnt_en,
  output logic [3:0]        Cnt_data,
  input  logic [NSYM*CW-1:0] Num_bus,
  output logic              Out_valid,
  input  logic              Out_ready,
  output logic [3:0]        Out_sym,
  output logic [CW-1:0]     Out_freq,
  output logic              Out_last,
  output logic [8:0]        Total,
  output logic              Err_overflow
);

  localparam int IW = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_COUNT,
    S_SETTLE,
    S_DUMP,
    S_DONE
  } state_t;

  state_t        state, state_nx;
  logic [IW-1:0] idx;
  logic          settle_cnt;
  logic          cnt_en_r;
  logic [3:0]    cnt_data_r;
  logic [8:0]    total_r;
  logic          err_r;

  logic          sym_xfer;
  logic          sym_countable;
  logic          at_max;

  logic [IW-1:0] cur;
  logic          ent_valid;
  logic          ent_last;
  logic [CW-1:0] cur_freq;
  logic          accept;

  assign sym_xfer      = Sym_valid && (state == S_COUNT);
  assign sym_countable = (int'(Sym_data) < NSYM);
  assign at_max        = (total_r == 9'(MAX_SYMS - 1));

`ifdef FREQ_SKIP_ZERO_EN
  logic [NSYM-1:0] nz_mask;
  logic [IW-1:0]   last_nz;

  // Pick the lowest nonzero entry at or above idx, and the highest nonzero entry
  always_comb begin
    nz_mask   = '0;
    cur       = '0;
    ent_valid = 1'b0;
    last_nz   = '0;
    for (int unsigned k = 0; k < NSYM; k++) begin
      nz_mask[k] = |Num_bus[k*CW +: CW];
    end
    for (int unsigned k = 0; k < NSYM; k++) begin
      if (nz_mask[k]) last_nz = IW'(k);
    end
    // Descending scan so the lowest qualifying index wins
    for (int unsigned j = 0; j < NSYM; j++) begin
      if (nz_mask[NSYM-1-j] && (IW'(NSYM-1-j) >= idx)) begin
        cur       = IW'(NSYM-1-j);
        ent_valid = 1'b1;
      end
    end
    ent_last = ent_valid && (cur == last_nz);
  end
`else
  // Every entry is emitted in order; the final one carries the last flag
  always_comb begin
    cur       = idx;
    ent_valid = 1'b1;
    ent_last  = (idx == IW'(NSYM - 1));
  end
`endif

  // Frequency of the current entry, selected from the packed counter bus
  always_comb begin
    cur_freq = '0;
    for (int unsigned k = 0; k < NSYM; k++) begin
      if (cur == IW'(k)) cur_freq = Num_bus[k*CW +: CW];
    end
  end

  assign Out_valid = (state == S_DUMP) && ent_valid;
  assign accept    = Out_valid && Out_ready;

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (Go) state_nx = S_CLEAR;
      S_CLEAR:  state_nx = S_COUNT;
      S_COUNT: begin
        if (sym_xfer) begin
          if (!sym_countable)          state_nx = S_SETTLE;
          else if (Sym_last || at_max) state_nx = S_SETTLE;
        end
      end
      S_SETTLE: if (settle_cnt) state_nx = S_DUMP;
      S_DUMP: begin
        if (!ent_valid)              state_nx = S_DONE;
        else if (accept && ent_last) state_nx = S_DONE;
      end
      S_DONE:   state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge Clk_in or negedge nRst) begin
    if (!nRst) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Settle window counter and table index
  always_ff @(posedge Clk_in or negedge nRst) begin
    if (!nRst) begin
      settle_cnt <= 1'b0;
      idx        <= '0;
    end else begin
      settle_cnt <= (state == S_SETTLE) ? ~settle_cnt : 1'b0;
      if (state == S_SETTLE) idx <= '0;
      else if (accept)       idx <= cur + 1'b1;
    end
  end

  // Registered increment command, run total and overflow flag
  always_ff @(posedge Clk_in or negedge nRst) begin
    if (!nRst) begin
      cnt_en_r   <= 1'b0;
      cnt_data_r <= '0;
      total_r    <= '0;
      err_r      <= 1'b0;
    end else begin
      cnt_en_r <= sym_xfer && sym_countable;
      if (state == S_CLEAR) begin
        total_r <= '0;
        err_r   <= 1'b0;
      end else if (sym_xfer && sym_countable) begin
        cnt_data_r <= Sym_data;
        total_r    <= total_r + 1'b1;
        if (at_max && !Sym_last) err_r <= 1'b1;
      end
    end
  end

  assign Busy         = (state != S_IDLE);
  assign Done         = (state == S_DONE);
  assign Sym_ready    = (state == S_COUNT);
  assign Cnt_clr      = (state == S_CLEAR);
  assign Cnt_en       = cnt_en_r;
  assign Cnt_data     = cnt_data_r;
  assign Out_sym      = Out_valid ? cur : '0;
  assign Out_freq     = Out_valid ? cur_freq : '0;
  assign Out_last     = Out_valid && ent_last;
  assign Total        = total_r;
  assign Err_overflow = err_r;

endmodule

// File: tb/tb_freq_ctrl.sv
// tb_freq_ctrl: directed bench for freq_ctrl (default build). A small
// saturating counter stands in for the digit frequency counter so the
// dumped table can be checked against hand-computed frequencies.
module tb_freq_ctrl;

  localparam int NSYM = 10;
  localparam int CW   = 8;

  logic              Clk_in;
  logic              nRst;
  logic              Go;
  logic              Busy;
  logic              Done;
  logic              Sym_valid;
  logic [3:0]        Sym_data;
  logic              Sym_last;
  logic              Sym_ready;
  logic              Cnt_clr;
  logic              Cnt_en;
  logic [3:0]        Cnt_data;
  logic [NSYM*CW-1:0] Num_bus;
  logic              Out_valid;
  logic              Out_ready;
  logic [3:0]        Out_sym;
  logic [CW-1:0]     Out_freq;
  logic              Out_last;
  logic [8:0]        Total;
  logic              Err_overflow;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_freq [NSYM];
  logic [7:0] cnt [NSYM];

  freq_ctrl #(.NSYM(NSYM), .CW(CW), .MAX_SYMS(255)) dut (
    .Clk_in(Clk_in), .nRst(nRst), .Go(Go), .Busy(Busy), .Done(Done),
    .Sym_valid(Sym_valid), .Sym_data(Sym_data), .Sym_last(Sym_last),
    .Sym_ready(Sym_ready), .Cnt_clr(Cnt_clr), .Cnt_en(Cnt_en),
    .Cnt_data(Cnt_data), .Num_bus(Num_bus), .Out_valid(Out_valid),
    .Out_ready(Out_ready), .Out_sym(Out_sym), .Out_freq(Out_freq),
    .Out_last(Out_last), .Total(Total), .Err_overflow(Err_overflow)
  );

  initial begin
    Clk_in = 1'b0;
    forever #5 Clk_in = ~Clk_in;
  end

  // Stand-in frequency counter: clear, saturating increment
  always @(posedge Clk_in or negedge nRst) begin
    if (!nRst) begin
      for (int k = 0; k < NSYM; k++) cnt[k] <= '0;
    end else if (Cnt_clr) begin
      for (int k = 0; k < NSYM; k++) cnt[k] <= '0;
    end else if (Cnt_en && (int'(Cnt_data) < NSYM)) begin
      if (cnt[Cnt_data] != 8'hFF) cnt[Cnt_data] <= cnt[Cnt_data] + 1'b1;
    end
  end

  // Pack counter values onto the bus
  always_comb begin
    Num_bus = '0;
    for (int k = 0; k < NSYM; k++) Num_bus[k*CW +: CW] = cnt[k];
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge Clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_exp;
    for (int k = 0; k < NSYM; k++) exp_freq[k] = '0;
  endtask

  task automatic start_run;
    chk("idle_busy", Busy, 0);
    Go = 1'b1;
    tick;
    Go = 1'b0;
    chk("clear_pulse", Cnt_clr, 1);
    chk("clear_busy", Busy, 1);
    chk("clear_ready", Sym_ready, 0);
    tick;
    chk("count_clr_low", Cnt_clr, 0);
    chk("count_ready", Sym_ready, 1);
    chk("count_total0", Total, 0);
    chk("count_err0", Err_overflow, 0);
  endtask

  task automatic send(input logic [3:0] d, input logic l, input logic exp_en,
                      input logic [8:0] exp_total);
    Sym_valid = 1'b1;
    Sym_data  = d;
    Sym_last  = l;
    chk("send_ready", Sym_ready, 1);
    tick;
    Sym_valid = 1'b0;
    Sym_last  = 1'b0;
    chk("cnt_en", Cnt_en, exp_en);
    if (exp_en) chk("cnt_data", Cnt_data, d);
    chk("total", Total, exp_total);
  endtask

  // Called in the first settle cycle; returns in the first dump cycle
  task automatic settle_to_dump;
    chk("settle1_ready", Sym_ready, 0);
    chk("settle1_ovalid", Out_valid, 0);
    tick;
    chk("settle2_cnt_en", Cnt_en, 0);
    chk("settle2_ready", Sym_ready, 0);
    chk("settle2_ovalid", Out_valid, 0);
    chk("settle2_busy", Busy, 1);
    tick;
  endtask

  task automatic dump_check(input bit rnd);
    bit accepted;
    for (int k = 0; k < NSYM; k++) begin
      accepted = 1'b0;
      for (int t = 0; t < 16 && !accepted; t++) begin
        chk("dump_valid", Out_valid, 1);
        chk("dump_sym", Out_sym, k);
        chk("dump_freq", Out_freq, exp_freq[k]);
        chk("dump_last", Out_last, (k == NSYM - 1));
        if (!rnd || t >= 7) Out_ready = 1'b1;
        else Out_ready = 1'($urandom_range(0, 1));
        tick;
        if (Out_ready) accepted = 1'b1;
      end
    end
    Out_ready = 1'b0;
    chk("done_pulse", Done, 1);
    chk("done_ovalid", Out_valid, 0);
    chk("done_busy", Busy, 1);
    tick;
    chk("post_done", Done, 0);
    chk("post_busy", Busy, 0);
  endtask

  task automatic reset_pulse;
    nRst = 1'b0;
    #1;
    chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0);
    chk("rst_ready", Sym_ready, 0);
    chk("rst_clr", Cnt_clr, 0);
    chk("rst_cnt_en", Cnt_en, 0);
    chk("rst_cnt_data", Cnt_data, 0);
    chk("rst_ovalid", Out_valid, 0);
    chk("rst_osym", Out_sym, 0);
    chk("rst_ofreq", Out_freq, 0);
    chk("rst_olast", Out_last, 0);
    chk("rst_total", Total, 0);
    chk("rst_err", Err_overflow, 0);
    #2;
    nRst = 1'b1;
    tick;
    chk("rst_rel_busy", Busy, 0);
    chk("rst_rel_done", Done, 0);
  endtask

  initial begin
    nRst = 1'b0; Go = 1'b0; Sym_valid = 1'b0; Sym_data = '0;
    Sym_last = 1'b0; Out_ready = 1'b0;
    #2;
    reset_pulse;

    // Run 1: 3,3,7 (last on 7), Go held high during COUNT is ignored
    clear_exp; exp_freq[3] = 8'd2; exp_freq[7] = 8'd1;
    start_run;
    Go = 1'b1;
    tick;
    Go = 1'b0;
    chk("go_ignored_clr", Cnt_clr, 0);
    chk("go_ignored_ready", Sym_ready, 1);
    chk("idle_cnt_en", Cnt_en, 0);
    send(4'd3, 1'b0, 1'b1, 9'd1);
    send(4'd3, 1'b0, 1'b1, 9'd2);
    send(4'd7, 1'b1, 1'b1, 9'd3);
    settle_to_dump;
    dump_check(1'b0);
    chk("r1_total", Total, 3);
    chk("r1_err", Err_overflow, 0);

    // Run 2: 1,2 then terminator 0xA
    clear_exp; exp_freq[1] = 8'd1; exp_freq[2] = 8'd1;
    start_run;
    send(4'd1, 1'b0, 1'b1, 9'd1);
    send(4'd2, 1'b0, 1'b1, 9'd2);
    send(4'hA, 1'b0, 1'b0, 9'd2);
    settle_to_dump;
    dump_check(1'b0);
    chk("r2_total", Total, 2);
    chk("r2_err", Err_overflow, 0);

    // Run 3: 256 symbols of 5 with no last; truncated at 255, random stalls
    clear_exp; exp_freq[5] = 8'd255;
    start_run;
    for (int i = 0; i < 255; i++) send(4'd5, 1'b0, 1'b1, 9'(i + 1));
    Sym_valid = 1'b1;
    Sym_data  = 4'd5;
    chk("ovf_err", Err_overflow, 1);
    chk("ovf_total", Total, 255);
    settle_to_dump;
    Sym_valid = 1'b0;
    chk("ovf_total_hold", Total, 255);
    dump_check(1'b1);
    chk("r3_total", Total, 255);
    chk("r3_err", Err_overflow, 1);

    // Reset during COUNT
    start_run;
    send(4'd2, 1'b0, 1'b1, 9'd1);
    reset_pulse;

    // Reset during DUMP, then a clean run
    start_run;
    send(4'd0, 1'b1, 1'b1, 9'd1);
    settle_to_dump;
    chk("dump_pre_rst_valid", Out_valid, 1);
    chk("dump_pre_rst_freq", Out_freq, 1);
    reset_pulse;
    clear_exp; exp_freq[9] = 8'd1;
    start_run;
    send(4'd9, 1'b1, 1'b1, 9'd1);
    settle_to_dump;
    dump_check(1'b1);
    chk("r5_total", Total, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
